// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic fill.
// busy is high while shifting; done pulses for one cycle when shifted holds the result.
module shift_right_seq #(
  parameter int WIDTH     = 16,
  parameter int AMT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 arith,
  input  logic [WIDTH-1:0]     to_shift,
  input  logic [AMT_WIDTH-1:0] shift_bits,
  output logic [WIDTH-1:0]     shifted,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              arith_q, arith_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  amt_clamped;
  logic              fill;
  logic              accept;

  // Amounts at or beyond the data width all behave like a full-width shift.
  always_comb begin
    amt_clamped = shift_bits[CNT_W-1:0];
    if (shift_bits >= AMT_WIDTH'(WIDTH)) begin
      amt_clamped = CNT_W'(WIDTH);
    end
  end

  assign fill   = arith_q & data_q[WIDTH-1];
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    arith_d = arith_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          data_d  = to_shift;
          count_d = amt_clamped;
          arith_d = arith;
          state_d = (amt_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = {fill, data_q[WIDTH-1:1]};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      arith_q <= arith_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign shifted = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
